// File: rtl/bus_ram_responder.sv
// Data-bus RAM responder: byte-masked writes, registered reads, LATENCY-cycle completion pulse.
// Optional macro BUS_RAM_ERR_EN adds bus_err and blocks out-of-range accesses instead of wrapping.
module bus_ram_responder #(
    parameter int          SIZE_W    = 4096,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter              INIT_H    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wmask,
    input  logic        bus_ren,
    input  logic        bus_wen,
    output logic [31:0] bus_rdata,
    output logic        bus_done
`ifdef BUS_RAM_ERR_EN
    ,
    output logic        bus_err
`endif
);

    localparam int         AW       = $clog2(SIZE_W);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        kind_q, kind_d;
    logic        err_q, err_d;
    logic [31:0] hold_q, hold_d;

    logic [31:0] offset;
    logic [AW-1:0] word_idx;
    logic        oor;
    logic        accept;
    logic        wr_go;
    logic        rd_go;
    logic [3:0]  byte_we;
    logic [31:0] ram_rd_q;
    logic [31:0] rd_word;
    logic        unused_bits;

    logic [31:0] mem [SIZE_W];

    assign offset   = bus_addr - BASE_ADDR;
    assign word_idx = offset[AW+1:2];

`ifdef BUS_RAM_ERR_EN
    // Below BASE_ADDR wraps to a huge offset, so one upper-bit test covers both bounds.
    assign oor         = |offset[31:AW+2];
    assign unused_bits = ^offset[1:0];
`else
    assign oor         = 1'b0;
    assign unused_bits = ^{offset[31:AW+2], offset[1:0]};
`endif

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && (bus_ren || bus_wen);
    assign wr_go  = accept && bus_wen && !oor;
    assign rd_go  = accept && !bus_wen;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_we[gi] = wr_go && bus_wmask[gi];
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_we[b]) begin
                mem[word_idx][b*8 +: 8] <= bus_wdata[b*8 +: 8];
            end
        end
        if (rd_go) begin
            ram_rd_q <= mem[word_idx];
        end
    end

    assign rd_word = err_q ? 32'h0 : ram_rd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        err_d   = err_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && !kind_q) begin
                    hold_d = rd_word;
                end
                if (accept) begin
                    kind_d = bus_wen;
                    err_d  = oor;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            kind_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    // Fresh read data is only visible in its DONE cycle; otherwise the last read word is held.
    assign bus_done  = (state_q == DONE);
    assign bus_rdata = (bus_done && !kind_q) ? rd_word : hold_q;

`ifdef BUS_RAM_ERR_EN
    assign bus_err = bus_done && err_q;
`endif

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: one LATENCY=1 and one LATENCY=3 instance, scoreboarded completions.
module tb_bus_ram_responder;

    logic        clk = 1'b0;
    logic        rst_s   [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  wmask_s [2];
    logic        ren_s   [2];
    logic        wen_s   [2];
    logic [31:0] rdata_s [2];
    logic        done_s  [2];
`ifdef BUS_RAM_ERR_EN
    logic        err_s   [2];
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t vecs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_ram_responder #(.SIZE_W(4096), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
        .clk(clk), .rst(rst_s[0]), .bus_addr(addr_s[0]), .bus_wdata(wdata_s[0]),
        .bus_wmask(wmask_s[0]), .bus_ren(ren_s[0]), .bus_wen(wen_s[0]),
        .bus_rdata(rdata_s[0]), .bus_done(done_s[0])
`ifdef BUS_RAM_ERR_EN
        , .bus_err(err_s[0])
`endif
    );

    bus_ram_responder #(.SIZE_W(4096), .LATENCY(3), .BASE_ADDR(32'h0)) u_lat3 (
        .clk(clk), .rst(rst_s[1]), .bus_addr(addr_s[1]), .bus_wdata(wdata_s[1]),
        .bus_wmask(wmask_s[1]), .bus_ren(ren_s[1]), .bus_wen(wen_s[1]),
        .bus_rdata(rdata_s[1]), .bus_done(done_s[1])
`ifdef BUS_RAM_ERR_EN
        , .bus_err(err_s[1])
`endif
    );

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Drive a request from a negedge, hold it until the responder can accept, record the expectation.
    task automatic issue(input int s, input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m,
                         input logic [31:0] er, input logic ee);
        exp_t e;
        int   w;
        addr_s[s]  = a;
        wdata_s[s] = wd;
        wmask_s[s] = m;
        wen_s[s]   = we;
        ren_s[s]   = re;
        w = 0;
        while (qsize(s) != 0 && !done_s[s]) begin
            @(negedge clk);
            w++;
            if (w > 64) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout inst%0d: waited %0d cycles, required <= 64", s, w);
                break;
            end
        end
        @(posedge clk);
        #1;
        e.rdata = er;
        e.err   = ee;
        e.acc   = cyc;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
        wen_s[s] = 1'b0;
        ren_s[s] = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input int s);
        int w;
        w = 0;
        while (qsize(s) != 0) begin
            @(negedge clk);
            w++;
            if (w > 64) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout inst%0d: %0d completions still pending", s, qsize(s));
                if (s == 0) q0.delete();
                else        q1.delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic mon(input int s);
        exp_t e;
        int   lat;
        logic err_ok;
        if (!done_s[s]) return;
        tests++;
        if (qsize(s) == 0) begin
            fails++;
            $display("FAIL spurious_done inst%0d: done with no accepted request, rdata %08h", s, rdata_s[s]);
            return;
        end
        if (s == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        lat = cyc - e.acc + 1;
`ifdef BUS_RAM_ERR_EN
        err_ok = (err_s[s] === e.err);
`else
        err_ok = 1'b1;
`endif
        $display("[TB] inst%0d done at cycle %0d: rdata=%08h latency=%0d", s, cyc, rdata_s[s], lat);
        if (rdata_s[s] !== e.rdata || lat != lat_of(s) || !err_ok) begin
            fails++;
            $display("FAIL completion inst%0d: rdata %08h latency %0d err_ok %0b, required rdata %08h latency %0d err %0b",
                     s, rdata_s[s], lat, err_ok, e.rdata, lat_of(s), e.err);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_s[s] = 1'b1; addr_s[s] = '0; wdata_s[s] = '0;
            wmask_s[s] = '0; ren_s[s] = 1'b0; wen_s[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        check("reset_done_l1",  {31'b0, done_s[0]}, 32'h0);
        check("reset_rdata_l1", rdata_s[0], 32'h0);
        check("reset_done_l3",  {31'b0, done_s[1]}, 32'h0);
        check("reset_rdata_l3", rdata_s[1], 32'h0);

        // we, re, addr, wdata, mask, expected rdata during done, expected err
        vecs.push_back('{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h20, 32'hAAAAAAAA, 4'h4, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h20, 32'h0,        4'h0, 32'h11AA3344, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h11AA3344, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,  32'h1,        4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h4,  32'h2,        4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0,  32'h0,        4'h0, 32'h1,        1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h4,  32'h0,        4'h0, 32'h2,        1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h8,  32'h0BADF00D, 4'hF, 32'h2,        1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h8,  32'h0,        4'h0, 32'h0BADF00D, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h13, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
`ifdef BUS_RAM_ERR_EN
        vecs.push_back('{1'b1, 1'b0, 32'h4000, 32'h5A5A5A5A, 4'hF, 32'hDEADBEEF, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h0,    32'h0,        4'h0, 32'h1,        1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h4000, 32'h0,        4'h0, 32'h0,        1'b1});
`else
        vecs.push_back('{1'b1, 1'b0, 32'h4000, 32'h5A5A5A5A, 4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0,    32'h0,        4'h0, 32'h5A5A5A5A, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h4000, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0});
`endif

        // Consecutive table entries are issued back-to-back, so each accept lands in the prior DONE cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                  vecs[i].exp_rdata, vecs[i].exp_err);
        end
        drain(0);

        // Second request is raised during WAIT and must wait for the DONE cycle.
        issue(1, 1'b1, 1'b0, 32'h4, 32'h77778888, 4'hF, 32'h0, 1'b0);
        issue(1, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, 32'h77778888, 1'b0);
        drain(1);

        // Reset during a write's WAIT: the write is already committed.
        issue(1, 1'b1, 1'b0, 32'h34, 32'h12345678, 4'hF, 32'h77778888, 1'b0);
        rst_s[1] = 1'b1;
        @(posedge clk);
        #1;
        q1.delete();
        @(negedge clk);
        rst_s[1] = 1'b0;
        check("rst_wr_done",  {31'b0, done_s[1]}, 32'h0);
        check("rst_wr_rdata", rdata_s[1], 32'h0);

        // Reset during a read's WAIT: the read is dropped with no completion.
        issue(1, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, 32'h77778888, 1'b0);
        rst_s[1] = 1'b1;
        @(posedge clk);
        #1;
        q1.delete();
        @(negedge clk);
        rst_s[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rst_rd_no_done", {31'b0, done_s[1]}, 32'h0);
            check("rst_rd_rdata",   rdata_s[1], 32'h0);
            @(negedge clk);
        end

        issue(1, 1'b0, 1'b1, 32'h34, 32'h0, 4'h0, 32'h12345678, 1'b0);
        drain(1);
        check("post_rst_hold", rdata_s[1], 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
